alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
- Arbitrates between two requesters sharing the signed ALU's four execution units (arithmetic, logic, compare, shift).
- Sequences each accepted operation: drives operands, a 2-bit function code and a one-cycle unit enable, waits for that unit's registered flag, then returns the result with the requester's ID.
- Sits between the command sources and the ALU unit instances, one operation in flight at a time.

Parameters:
WIDTH, 16, operand/result width (signed two's complement)
TIMEOUT, 4, max WAIT cycles for a unit flag before an error response; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand A (signed)
req0_b  in  WIDTH  requester 0 operand B (signed)
req0_fun  in  4  requester 0 op: [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function
req1_valid, req1_ready, req1_a, req1_b, req1_fun  same as requester 0, for requester 1
unit_a  out  WIDTH  operand A to all units (registered)
unit_b  out  WIDTH  operand B to all units (registered)
unit_fun  out  2  function code to all units (registered)
unit_en  out  4  one-hot enables {shift,cmp,logic,arith} (registered)
arith_out, logic_out, cmp_out, shift_out  in  WIDTH  registered unit results
unit_flag  in  4  unit done flags {shift,cmp,logic,arith}
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the operation
rsp_data  out  WIDTH  captured result
rsp_err  out  1  1 = unit timed out, rsp_data = 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE, every registered output 0 (unit_a, unit_b, unit_fun, unit_en, rsp_valid, rsp_id, rsp_data, rsp_err), busy 0, rr pointer = 1 (requester 0 wins first), timeout counter 0. reqN_ready forced 0 while rst low. An in-flight operation is dropped silently; no response.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant requester 0 if only req0_valid; requester 1 if only req1_valid.
  - If both are valid, grant the requester not in the rr pointer.
  - reqN_ready = grant, combinational, asserted only in IDLE.
  - On the accept edge: latch a, b, fun[1:0] onto the unit outputs; latch unit select and rsp_id; update the rr pointer to the granted ID; go to ISSUE.
- ISSUE (1 cycle): unit_en = one-hot of the selected unit for exactly this cycle. Next state WAIT, counter cleared.
- WAIT:
  - unit_en = 0.
  - If unit_flag[sel] = 1: capture the selected unit's output into rsp_data, set rsp_err = 0 and rsp_valid = 1, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT: rsp_data = 0, rsp_err = 1, rsp_valid = 1, go to RESP.
  - Flags of non-selected units are ignored.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready = 1.
  - On that edge rsp_valid = 0, go to IDLE.
  - No request is accepted while in RESP; the next grant occurs in the following IDLE cycle.
- Latency with a unit whose flag asserts one cycle after enable:
  - accept at cycle 0, unit_en high at cycle 1, flag at cycle 2, rsp_valid at cycle 3.
  - With rsp_ready tied high, the next accept is at cycle 4 (throughput 1 op / 4 cycles).
- unit_a, unit_b and unit_fun hold their values after ISSUE until the next accept, so units see stable operands.
- Operands pass through unmodified; no width arithmetic in this block. rsp_data is the raw signed unit result.
- Requester valid deasserting without ready: no effect, no accept.

Test Plan:
- Reset, then req0: a=5, b=5, fun=4'b1001 (cmp, equal) with a compare-unit model -> req0_ready high at cycle 0; unit_en=4'b0100 only at cycle 1; rsp_valid at cycle 3 with rsp_id=0, rsp_data=1, rsp_err=0.
- req0 and req1 held valid continuously; req0: a=-3, b=2, fun=4'b1011 (cmp, less); req1: a=7, b=-1, fun=4'b1010 (cmp, greater) -> grants alternate 0,1,0,1; responses rsp_data=3 for ID 0 and 2 for ID 1; no grant in ISSUE/WAIT/RESP.
- Unit model never raises its flag, TIMEOUT=4, fun=4'b0000 -> after 4 WAIT cycles rsp_valid=1, rsp_err=1, rsp_data=0; FSM returns to IDLE after rsp_ready.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_data, rsp_id and rsp_err stable; reqN_ready stays 0; one cycle after rsp_ready rises, IDLE accepts the pending request.
- rst pulsed low during WAIT -> all outputs 0 immediately (asynchronous); after release, no stale response; the next request is served normally with requester 0 favoured.
- Spurious unit_flag[0] high while sel=cmp in WAIT -> ignored; response taken only on unit_flag[2] with cmp_out data.

Source files
------------

// File: rtl/alu_op_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_scheduler_if
// Brief    : Requester, ALU-unit and response bundle for alu_op_scheduler.
// Revision : 1.0
// ============================================================================
interface alu_op_scheduler_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_fun;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_fun;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic [1:0]       unit_fun;
    logic [3:0]       unit_en;
    logic [WIDTH-1:0] arith_out;
    logic [WIDTH-1:0] logic_out;
    logic [WIDTH-1:0] cmp_out;
    logic [WIDTH-1:0] shift_out;
    logic [3:0]       unit_flag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  arith_out, logic_out, cmp_out, shift_out, unit_flag, rsp_ready,
        output req0_ready, req1_ready, unit_a, unit_b, unit_fun, unit_en,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output arith_out, logic_out, cmp_out, shift_out, unit_flag, rsp_ready,
        input  req0_ready, req1_ready, unit_a, unit_b, unit_fun, unit_en,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_scheduler
// Brief    : Round-robin arbiter and sequencer for two requesters sharing
//            four ALU execution units, one operation in flight.
// Revision : 1.0
// ============================================================================
module alu_op_scheduler #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_op_scheduler_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic             rr_q;
    logic [1:0]       sel_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] unit_a_q;
    logic [WIDTH-1:0] unit_b_q;
    logic [1:0]       unit_fun_q;
    logic [3:0]       unit_en_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             busy_q;

    logic             w_any_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [3:0]       w_sel_fun;
    logic             w_flag;
    logic [WIDTH-1:0] w_unit_res;

    // On contention the requester that was not granted last time wins.
    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    assign w_grant_id  = bus.req0_valid ? (bus.req1_valid ? ~rr_q : 1'b0) : 1'b1;
    assign w_accept    = rst && (state_q == S_IDLE) && w_any_valid;

    assign bus.req0_ready = w_accept & ~w_grant_id;
    assign bus.req1_ready = w_accept &  w_grant_id;

    assign w_sel_a   = w_grant_id ? bus.req1_a   : bus.req0_a;
    assign w_sel_b   = w_grant_id ? bus.req1_b   : bus.req0_b;
    assign w_sel_fun = w_grant_id ? bus.req1_fun : bus.req0_fun;

    assign w_flag = bus.unit_flag[sel_q];

    always_comb begin
        w_unit_res = bus.arith_out;
        case (sel_q)
            2'd0:    w_unit_res = bus.arith_out;
            2'd1:    w_unit_res = bus.logic_out;
            2'd2:    w_unit_res = bus.cmp_out;
            default: w_unit_res = bus.shift_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b1;
            sel_q       <= 2'd0;
            cnt_q       <= '0;
            unit_a_q    <= '0;
            unit_b_q    <= '0;
            unit_fun_q  <= 2'd0;
            unit_en_q   <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        unit_a_q   <= w_sel_a;
                        unit_b_q   <= w_sel_b;
                        unit_fun_q <= w_sel_fun[1:0];
                        sel_q      <= w_sel_fun[3:2];
                        unit_en_q  <= 4'b0001 << w_sel_fun[3:2];
                        rsp_id_q   <= w_grant_id;
                        rr_q       <= w_grant_id;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    unit_en_q <= 4'd0;
                    cnt_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_flag) begin
                        rsp_data_q  <= w_unit_res;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // This cycle is the TIMEOUT-th flagless WAIT cycle.
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.unit_a    = unit_a_q;
    assign bus.unit_b    = unit_b_q;
    assign bus.unit_fun  = unit_fun_q;
    assign bus.unit_en   = unit_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_scheduler
// Brief    : Scoreboard bench for alu_op_scheduler with a delayable unit model.
// Revision : 1.0
// ============================================================================
module tb_alu_op_scheduler;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_scheduler_if #(.WIDTH(WIDTH)) bus();
    alu_op_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_rsp  = 0;
    exp_t sb[$];
    int   g_id[$];
    int   g_cyc[$];

    int         delay = 1;
    bit         dead  = 1'b0;
    logic [3:0] spur_flag = 4'd0;

    // External unit behaviour: a = unit_a, b = unit_b, fun = {unit, function}.
    function automatic logic [WIDTH-1:0] unit_model(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [3:0] fun);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb2;
        logic cond;
        sa = a; sb2 = b; cond = 1'b0;
        unit_model = '0;
        case (fun[3:2])
            2'd0: case (fun[1:0])
                2'd0: unit_model = a + b;
                2'd1: unit_model = a - b;
                2'd2: unit_model = a;
                default: unit_model = -a;
            endcase
            2'd1: case (fun[1:0])
                2'd0: unit_model = a & b;
                2'd1: unit_model = a | b;
                2'd2: unit_model = a ^ b;
                default: unit_model = ~a;
            endcase
            2'd2: begin
                case (fun[1:0])
                    2'd0: cond = (sa != sb2);
                    2'd1: cond = (sa == sb2);
                    2'd2: cond = (sa >  sb2);
                    default: cond = (sa < sb2);
                endcase
                unit_model = cond ? WIDTH'(fun[1:0]) : '0;
            end
            default: case (fun[1:0])
                2'd0: unit_model = a << b[3:0];
                2'd1: unit_model = a >> b[3:0];
                2'd2: unit_model = WIDTH'(sa >>> b[3:0]);
                default: unit_model = a;
            endcase
        endcase
    endfunction

    logic [3:0]       m_flag;
    logic [1:0]       m_unit;
    logic [WIDTH-1:0] m_res;
    int               m_cnt;
    logic [1:0]       en_idx;
    logic [WIDTH-1:0] en_res;
    logic             fire_now;
    logic [1:0]       fire_idx;
    logic [WIDTH-1:0] fire_res;

    always_comb begin
        en_idx = 2'd0;
        case (bus.unit_en)
            4'b0010: en_idx = 2'd1;
            4'b0100: en_idx = 2'd2;
            4'b1000: en_idx = 2'd3;
            default: en_idx = 2'd0;
        endcase
        en_res   = unit_model(bus.unit_a, bus.unit_b, {en_idx, bus.unit_fun});
        fire_now = (bus.unit_en != 4'd0) ? (!dead && delay <= 1) : (m_cnt == 1);
        fire_idx = (bus.unit_en != 4'd0) ? en_idx : m_unit;
        fire_res = (bus.unit_en != 4'd0) ? en_res : m_res;
    end

    assign bus.unit_flag = m_flag | spur_flag;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_flag        <= 4'd0;
            m_cnt         <= 0;
            m_unit        <= 2'd0;
            m_res         <= '0;
            bus.arith_out <= 16'hA5A5;
            bus.logic_out <= 16'h5A5A;
            bus.cmp_out   <= 16'h0F0F;
            bus.shift_out <= 16'hF0F0;
        end else begin
            m_flag <= 4'd0;
            if (bus.unit_en != 4'd0) begin
                m_unit <= en_idx;
                m_res  <= en_res;
                m_cnt  <= (dead || delay <= 1) ? 0 : delay - 1;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
            if (fire_now) begin
                m_flag[fire_idx] <= 1'b1;
                case (fire_idx)
                    2'd0: bus.arith_out <= fire_res;
                    2'd1: bus.logic_out <= fire_res;
                    2'd2: bus.cmp_out   <= fire_res;
                    default: bus.shift_out <= fire_res;
                endcase
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back('{1'b0, dead ? '0 : unit_model(bus.req0_a, bus.req0_b, bus.req0_fun), dead});
                g_id.push_back(0); g_cyc.push_back(cyc);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back('{1'b1, dead ? '0 : unit_model(bus.req1_a, bus.req1_b, bus.req1_fun), dead});
                g_id.push_back(1); g_cyc.push_back(cyc);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                exp_t e;
                checks++;
                n_rsp++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got id=%0d data=%0h err=%0d, expected no response",
                             bus.rsp_id, bus.rsp_data, bus.rsp_err);
                end else begin
                    e = sb.pop_front();
                    if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {e.id, e.data, e.err}) begin
                        errors++;
                        $display("FAIL scoreboard_rsp: got id=%0d data=%0h err=%0d, expected id=%0d data=%0h err=%0d",
                                 bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_fun = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_fun = 4'd0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bus.unit_a, bus.unit_b, bus.unit_fun, bus.unit_en} !== '0) begin
            errors++;
            $display("FAIL reset_unit: got a=%0h b=%0h fun=%0h en=%0h, expected all 0",
                     bus.unit_a, bus.unit_b, bus.unit_fun, bus.unit_en);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%0d id=%0d data=%0h err=%0d busy=%0d, expected all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.busy);
        end
        tick();
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 00", {bus.req0_ready, bus.req1_ready});
        end
        bus.req0_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single();
        tick();
        bus.req0_a = WIDTH'(5); bus.req0_b = WIDTH'(5); bus.req0_fun = 4'b1001; bus.req0_valid = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_grant: got %b, expected 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0;
        #1;
        checks++;
        if ({bus.unit_en, bus.unit_a, bus.unit_b, bus.unit_fun, bus.busy} !== {4'b0100, WIDTH'(5), WIDTH'(5), 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL single_issue: got en=%b a=%0d b=%0d fun=%b busy=%0d, expected en=0100 a=5 b=5 fun=01 busy=1",
                     bus.unit_en, bus.unit_a, bus.unit_b, bus.unit_fun, bus.busy);
        end
        tick();
        checks++;
        if ({bus.unit_en, bus.rsp_valid} !== 5'd0) begin
            errors++;
            $display("FAIL single_wait: got en=%b rsp_valid=%0d, expected 0000 0", bus.unit_en, bus.rsp_valid);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, 1'b0, WIDTH'(1), 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got v=%0d id=%0d data=%0h err=%0d, expected 1 0 1 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_done: got v=%0d busy=%0d, expected 0 0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        rst = 1'b0; sb.delete(); tick(); rst = 1'b1;
        g_id.delete(); g_cyc.delete();
        r0 = n_rsp;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                bus.req0_a = WIDTH'(-3); bus.req0_b = WIDTH'(2);  bus.req0_fun = 4'b1011; bus.req0_valid = 1'b1;
                bus.req1_a = WIDTH'(7);  bus.req1_b = WIDTH'(-1); bus.req1_fun = 4'b1010; bus.req1_valid = 1'b1;
            end
            #1;
            checks++;
            if ((bus.req0_ready | bus.req1_ready) !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL b2b_grant_slot: cycle %0d got ready=%b, expected grant=%0d",
                         i, {bus.req0_ready, bus.req1_ready}, (i % 4 == 0));
            end
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        checks++;
        if (g_id.size() != 4 || g_id[0] != 0 || g_id[1] != 1 || g_id[2] != 0 || g_id[3] != 1) begin
            errors++;
            $display("FAIL b2b_order: got %0d grants, expected 4 alternating 0,1,0,1", g_id.size());
        end
        checks++;
        if (n_rsp - r0 != 4) begin
            errors++;
            $display("FAIL b2b_rsp_count: got %0d, expected 4", n_rsp - r0);
        end
    endtask

    task automatic test_timeout();
        dead = 1'b1;
        tick();
        bus.req0_a = WIDTH'(1); bus.req0_b = WIDTH'(2); bus.req0_fun = 4'b0000; bus.req0_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.req0_valid = 1'b0;
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early: cycle %0d got rsp_valid=1, expected 0", c);
            end
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {1'b1, 1'b1, WIDTH'(0)}) begin
            errors++;
            $display("FAIL timeout_rsp: got v=%0d err=%0d data=%0h, expected 1 1 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle: got v=%0d busy=%0d, expected 0 0", bus.rsp_valid, bus.busy);
        end
        dead = 1'b0;
    endtask

    task automatic test_backpressure();
        bit seen;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req1_a = WIDTH'(100); bus.req1_b = WIDTH'(3); bus.req1_fun = 4'b0101; bus.req1_valid = 1'b1;
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_a = WIDTH'(20); bus.req0_b = WIDTH'(2); bus.req0_fun = 4'b1100; bus.req0_valid = 1'b1;
        tick();
        for (int c = 3; c <= 7; c++) begin
            tick();
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req0_ready, bus.req1_ready}
                !== {1'b1, 1'b1, WIDTH'(103), 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got v=%0d id=%0d data=%0d err=%0d rdy=%b, expected 1 1 103 0 00",
                         c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, {bus.req0_ready, bus.req1_ready});
            end
        end
        tick();
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp_no_grant: got req0_ready=1, expected 0");
        end
        tick();
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: got req0_ready=%0d, expected 1", bus.req0_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = bus.rsp_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_second_rsp: got no rsp_valid in 10 cycles, expected a response");
        end
        tick();
    endtask

    task automatic test_async_reset();
        bit seen;
        dead = 1'b1;
        tick();
        bus.req0_a = WIDTH'(9); bus.req0_b = WIDTH'(9); bus.req0_fun = 4'b0001; bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.unit_a, bus.unit_b, bus.unit_fun, bus.unit_en, bus.rsp_valid, bus.rsp_err} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0d a=%0h b=%0h fun=%0h en=%0h v=%0d err=%0d, expected all 0",
                     bus.busy, bus.unit_a, bus.unit_b, bus.unit_fun, bus.unit_en, bus.rsp_valid, bus.rsp_err);
        end
        sb.delete();
        tick();
        tick();
        #2 rst = 1'b1;
        dead = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL async_stale_rsp: cycle %0d got rsp_valid=1, expected 0", c);
            end
        end
        tick();
        bus.req0_a = WIDTH'(3); bus.req0_b = WIDTH'(4); bus.req0_fun = 4'b0000; bus.req0_valid = 1'b1;
        bus.req1_a = WIDTH'(1); bus.req1_b = WIDTH'(1); bus.req1_fun = 4'b0001; bus.req1_valid = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL async_rr_start: got %b, expected 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = bus.rsp_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL async_serve: got no rsp_valid in 10 cycles, expected a response");
        end
        tick();
    endtask

    task automatic test_spurious_flag();
        delay = 3;
        tick();
        bus.req0_a = WIDTH'(4); bus.req0_b = WIDTH'(9); bus.req0_fun = 4'b1011; bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        spur_flag = 4'b0001;
        for (int c = 3; c <= 4; c++) begin
            tick();
            if (c == 4) spur_flag = 4'b0000;
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_taken: cycle %0d got rsp_valid=1, expected 0", c);
            end
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, 1'b0, WIDTH'(3), 1'b0}) begin
            errors++;
            $display("FAIL spurious_rsp: got v=%0d id=%0d data=%0h err=%0d, expected 1 0 3 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        tick();
        delay = 1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_async_reset();
        test_spurious_flag();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
